// File: rtl/pim_shift_add_acc.sv
// pim_shift_add_acc
// Bit-serial shift-and-add accumulator fed by the four ADC partial sums
// (HH/HL/LH/LL) of the conv_top crossbar quad. One beat per input bit
// position; after BITS beats a saturated result is offered on a
// valid/ready output that holds until the consumer takes it.

module pim_shift_add_acc #(
   parameter int ADC_P   = 4,
   parameter int INPUT_P = 16,
   parameter int OUT_P   = 32,
   localparam int BITS   = INPUT_P / 2,
   localparam int IDX_W  = (BITS > 1) ? $clog2(BITS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADC_P-1:0]   adc_hh,
   input  logic [ADC_P-1:0]   adc_hl,
   input  logic [ADC_P-1:0]   adc_lh,
   input  logic [ADC_P-1:0]   adc_ll,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_P-1:0]   out_data,
   output logic               out_ovf,
   output logic [IDX_W-1:0]   bit_idx
);

   // Accumulator is wide enough that the largest possible BITS-beat sum
   // never wraps; saturation is decided on a copy extended past OUT_P.
   localparam int ACC_W = ADC_P + INPUT_P + BITS + 2;
   localparam int EXT_W = ((ACC_W > OUT_P) ? ACC_W : OUT_P) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_OUT
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nxt;
   logic [ACC_W-1:0]   term;
   logic [ACC_W-1:0]   sum;
   logic [EXT_W-1:0]   sum_ext;
   logic               sat;
   logic               accept;
   logic               last_beat;
   logic [IDX_W-1:0]   idx_nxt;
   logic               out_valid_nxt;
   logic [OUT_P-1:0]   out_data_nxt;
   logic               out_ovf_nxt;

   // A beat is only taken outside OUT, and never in a cycle that clear aborts.
   assign in_ready  = (state != S_OUT) && !clear;
   assign accept    = in_valid && in_ready;
   assign last_beat = (bit_idx == IDX_W'(BITS - 1));

   // Weight the four partial sums by their H/L halves, then by bit position
   // and fold into the running sum (a fresh result starts from zero in IDLE).
   always_comb begin
      term = (ACC_W'(adc_hh) << INPUT_P)
           + ((ACC_W'(adc_hl) + ACC_W'(adc_lh)) << (INPUT_P / 2))
           + ACC_W'(adc_ll);
      if (state == S_ACCUM) begin
         sum = acc + (term << bit_idx);
      end else begin
         sum = term;
      end
      sum_ext = EXT_W'(sum);
      sat     = |(sum_ext >> OUT_P);
   end

   // Next-state and next-register values; clear overrides everything else.
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      idx_nxt       = bit_idx;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      out_ovf_nxt   = out_ovf;
      if (clear) begin
         state_nxt     = S_IDLE;
         acc_nxt       = '0;
         idx_nxt       = '0;
         out_valid_nxt = 1'b0;
      end else begin
         case (state)
            S_IDLE, S_ACCUM: begin
               if (accept) begin
                  acc_nxt = sum;
                  if (last_beat) begin
                     idx_nxt       = '0;
                     state_nxt     = S_OUT;
                     out_valid_nxt = 1'b1;
                     out_data_nxt  = sat ? {OUT_P{1'b1}} : sum_ext[OUT_P-1:0];
                     out_ovf_nxt   = sat;
                  end else begin
                     idx_nxt   = bit_idx + IDX_W'(1);
                     state_nxt = S_ACCUM;
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_nxt = 1'b0;
                  state_nxt     = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         acc       <= '0;
         bit_idx   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         bit_idx   <= idx_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_ovf   <= out_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pim_shift_add_acc.sv
// tb_pim_shift_add_acc
// Drives a 32-bit-result and a 16-bit-result instance from the same inputs
// and checks both every cycle against an arithmetic model of the accumulator.

module tb_pim_shift_add_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  adc_hh = '0;
   logic [3:0]  adc_hl = '0;
   logic [3:0]  adc_lh = '0;
   logic [3:0]  adc_ll = '0;

   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ovf;
   logic [2:0]  bit_idx;

   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] out_data16;
   logic        out_ovf16;
   logic [2:0]  bit_idx16;

   int          total = 0;
   int          bad = 0;
   logic        ordy_sel = 1'b1;

   // Model state: whether a result is on offer, beats taken so far, sums.
   bit          m_out = 1'b0;
   int          m_cnt = 0;
   longint      m_sum = 0;
   longint      m_res = 0;

   pim_shift_add_acc #(.ADC_P(4), .INPUT_P(16), .OUT_P(32)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .adc_hh(adc_hh), .adc_hl(adc_hl), .adc_lh(adc_lh), .adc_ll(adc_ll),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .bit_idx(bit_idx)
   );

   pim_shift_add_acc #(.ADC_P(4), .INPUT_P(16), .OUT_P(16)) dut16 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
      .adc_hh(adc_hh), .adc_hl(adc_hl), .adc_lh(adc_lh), .adc_ll(adc_ll),
      .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
      .out_ovf(out_ovf16), .bit_idx(bit_idx16)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and are taken at the next one.
   task automatic applyStimulus(input logic v, input logic [3:0] hh, input logic [3:0] hl,
                                input logic [3:0] lh, input logic [3:0] ll,
                                input logic ordy, input logic clr);
      @(posedge clk);
      #1;
      in_valid  = v;
      adc_hh    = hh;
      adc_hl    = hl;
      adc_lh    = lh;
      adc_ll    = ll;
      out_ready = ordy;
      clear     = clr;
   endtask

   task automatic sendBeat(input logic [3:0] hh, input logic [3:0] hl,
                           input logic [3:0] lh, input logic [3:0] ll);
      applyStimulus(1'b1, hh, hl, lh, ll, ordy_sel, 1'b0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, ordy_sel, 1'b0);
   endtask

   // Called right after the last beat has been taken; the result must be
   // visible at the very next sample point.
   task automatic waitResult(input string nm, input longint e32, input longint eo32,
                             input longint e16, input longint eo16);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      checkOutput({nm, "_valid"}, out_valid, 1);
      checkOutput({nm, "_latency"}, n, 1);
      checkOutput({nm, "_data"}, out_data, e32);
      checkOutput({nm, "_ovf"}, out_ovf, eo32);
      checkOutput({nm, "_data16"}, out_data16, e16);
      checkOutput({nm, "_ovf16"}, out_ovf16, eo16);
   endtask

   // Reference: each accepted beat contributes its weighted value times 2^bit.
   always @(posedge clk or negedge rst) begin : model
      longint t;
      if (!rst) begin
         m_out = 1'b0;
         m_cnt = 0;
         m_sum = 0;
      end else if (clear) begin
         m_out = 1'b0;
         m_cnt = 0;
         m_sum = 0;
      end else if (m_out) begin
         if (out_ready) m_out = 1'b0;
      end else if (in_valid) begin
         t = longint'(adc_hh) * 65536 + (longint'(adc_hl) + longint'(adc_lh)) * 256
           + longint'(adc_ll);
         m_sum = m_sum + t * (longint'(1) << m_cnt);
         m_cnt++;
         if (m_cnt == 8) begin
            m_res = m_sum;
            m_out = 1'b1;
            m_cnt = 0;
            m_sum = 0;
         end
      end
   end

   // Compare both instances against the model at every falling edge.
   always @(negedge clk) begin : compare
      longint exp_rdy;
      longint e16;
      exp_rdy = (!m_out && !clear) ? 1 : 0;
      checkOutput("in_ready", in_ready, exp_rdy);
      checkOutput("in_ready16", in_ready16, exp_rdy);
      checkOutput("out_valid", out_valid, m_out);
      checkOutput("out_valid16", out_valid16, m_out);
      checkOutput("bit_idx", bit_idx, m_cnt);
      checkOutput("bit_idx16", bit_idx16, m_cnt);
      if (m_out) begin
         e16 = (m_res > 65535) ? 65535 : m_res;
         checkOutput("out_data", out_data, (m_res > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_res);
         checkOutput("out_ovf", out_ovf, (m_res > 64'hFFFF_FFFF) ? 1 : 0);
         checkOutput("out_data16", out_data16, e16);
         checkOutput("out_ovf16", out_ovf16, (m_res > 65535) ? 1 : 0);
      end
   end

   initial begin
      // Power-on reset values.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_ovf", out_ovf, 0);
      checkOutput("rst_idx", bit_idx, 0);
      checkOutput("rst_ready", in_ready, 1);
      rst = 1'b1;

      // Only the LL term, unit value at every bit: 2^8-1.
      for (int i = 0; i < 8; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd1);
      idle();
      waitResult("t1", 255, 0, 255, 0);

      // HH on bit 0 only lands at 2^16; the 16-bit instance saturates.
      sendBeat(4'd1, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 7; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd0);
      idle();
      waitResult("t2", 65536, 0, 65535, 1);

      // Full-scale sums on every beat: 15*66049*255.
      for (int i = 0; i < 8; i++) sendBeat(4'd15, 4'd15, 4'd15, 4'd15);
      idle();
      waitResult("t3", 252637425, 0, 65535, 1);

      // Back-pressure: result must hold while a new beat waits upstream.
      ordy_sel = 1'b0;
      for (int i = 0; i < 8; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd3);
      applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t4_hold_valid", out_valid, 1);
         checkOutput("t4_hold_data", out_data, 765);
         checkOutput("t4_hold_ready", in_ready, 0);
         applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
      end
      ordy_sel = 1'b1;
      applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
      idle();
      @(negedge clk);
      checkOutput("t4_release_valid", out_valid, 0);
      checkOutput("t4_release_idx", bit_idx, 0);
      checkOutput("t4_release_ready", in_ready, 1);

      // Asynchronous reset mid-accumulation discards the partial result.
      for (int i = 0; i < 3; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd1);
      idle();
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t5_rst_valid", out_valid, 0);
      checkOutput("t5_rst_data", out_data, 0);
      checkOutput("t5_rst_idx", bit_idx, 0);
      checkOutput("t5_rst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd1);
      idle();
      waitResult("t5", 255, 0, 255, 0);

      // Clear after four gappy beats, asserted alongside a valid beat.
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 2)) idle();
         sendBeat(4'd0, 4'd0, 4'd0, 4'd1);
      end
      applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t6_no_valid", out_valid, 0);
         checkOutput("t6_idx", bit_idx, 0);
      end
      for (int i = 0; i < 8; i++) sendBeat(4'd0, 4'd0, 4'd0, 4'd2);
      idle();
      waitResult("t6", 510, 0, 510, 0);

      // Random traffic: gaps, back-pressure and occasional clears.
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                       4'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
      end
      idle();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
